postfix_evaluator: RTL
======================

# postfix_evaluator

Stack-based evaluator that consumes the postfix token stream produced by the infix-to-postfix converter and computes the signed integer result. Tokens arrive one per cycle over a valid/ready handshake. Each token uses the same two-plane encoding as the converter: an 8-bit value plus an operator flag. The block sits at the back end of the stack-based ALU, between the converter output and the result register/display logic.

## Interface
- WIDTH, 8, operand/result width in bits (two's complement)
- DEPTH, 11, operand stack entries (max tokens per expression)
- CLK  in  1  rising-edge clock
- RST  in  1  reset, asynchronous, active-high
- tok_valid  in  1  token present
- tok_ready  out  1  block accepts token this cycle
- tok_is_op  in  1  1 = operator/paren token, 0 = operand
- tok_data  in  WIDTH  operand value, or ASCII operator code
- tok_last  in  1  final token of the expression
- done  out  1  one-cycle pulse, expression finished
- result  out  WIDTH  final value, held until next done
- err_code  out  3  0 none, 1 overflow, 2 underflow, 3 bad operator, 4 final depth ≠ 1; held until next done

## Operation
- Token transfer: a token transfers when tok_valid && tok_ready at the rising CLK edge.
- Internal stack: DEPTH×WIDTH register array; sp ranges 0..DEPTH.
- Operators: '+'=43, '-'=45, '*'=42.
  - Any other code with tok_is_op=1 is bad operator (err 3). This includes '('=40 and ')'=41.
- Arithmetic: modulo 2^WIDTH, two's complement.
  - '-' computes second-from-top minus top.
  - '*' keeps the low WIDTH bits of the product.
- FSM states: RUN, EXEC, DONE, DRAIN.
- RUN (tok_ready=1):
  - Operand accepted:
    - If sp==DEPTH → err 1, go to DRAIN. If tok_last is also set → go to DONE.
    - Otherwise push the operand and increment sp.
    - If tok_last → DONE, else stay in RUN.
  - Operator accepted:
    - Bad code → err 3. Otherwise, sp<2 → err 2.
    - On either error → DRAIN, or DONE if tok_last.
    - Otherwise latch the opcode and tok_last, go to EXEC.
- EXEC (tok_ready=0):
  - stack[sp-2] ← stack[sp-2] op stack[sp-1]; sp ← sp-1.
  - Next state: DONE if the latched last flag is set, else RUN.
- DRAIN (tok_ready=1):
  - Accept and discard tokens; the stack is not modified.
  - The tok_last transfer → DONE.
- DONE (tok_ready=0):
  - Assert done for exactly one cycle.
  - If no error is pending and sp≠1 → err_code 4.
  - result ← stack[0] when err_code==0, else 0.
  - Clear sp and the pending error; go to RUN.
- Error priority: the first error in an expression is the one reported. Later errors are ignored.
- Reset (any time, including mid-expression):
  - state=RUN, sp=0, pending error cleared.
  - done=0, result=0, err_code=0, tok_ready=0 while RST is high.
  - A token presented during reset is not consumed.

## Timing
- Operand token: 1 cycle of throughput.
- Operator token: 2 cycles (the accept cycle plus EXEC).
- done latency: asserts the cycle after the final token transfer, or the cycle after EXEC if the final token is an operator.
- result/err_code update on the same edge that raises done. Both are stable for the whole done cycle and after it.
- tok_ready is combinational from state and RST; it must not depend on tok_valid.
- tok_valid low in RUN or DRAIN: the block holds state indefinitely.
- Back-to-back expressions: the first token of the next expression is accepted the cycle after DONE.

## Test plan
- Tokens 5,4,2,'-',1,'+','*',6,'-' (last on the final '-'), tok_valid held high → done after 13 accepted/exec cycles; result=9, err_code=0.
- Tokens 100,3,'*' → result=44 (300 mod 256), err_code=0. Tokens 2,5,'-' → result=0xFD (-3).
- Tokens 7,'+',1,'+' → err_code=2 on the first '+'. The block drains to tok_last, then done=1 with result=0; the next expression 1,1,'+' → result=2.
- 12 operands with DEPTH=11 → err_code=1. Tokens 3,'(',4,'+' → err_code=3. Tokens 3,4 (last) → err_code=4.
- Random tok_valid gaps on the first vector → same result. tok_ready must be low exactly in EXEC and DONE cycles.
- RST asserted after the 4th token of the first vector → all outputs 0 and sp=0. The first vector is then resent and yields 9.

Source files
------------

// File: rtl/postfix_evaluator_if.sv
// Token stream from the infix-to-postfix converter into the evaluator.
// A token transfers on a rising clk edge where tok_valid && tok_ready; ready never depends on valid.
interface postfix_evaluator_if #(
    parameter int WIDTH = 8
);
    logic             tok_valid;
    logic             tok_ready;
    logic             tok_is_op;
    logic [WIDTH-1:0] tok_data;
    logic             tok_last;

    modport master (
        output tok_valid,
        output tok_is_op,
        output tok_data,
        output tok_last,
        input  tok_ready
    );

    modport slave (
        input  tok_valid,
        input  tok_is_op,
        input  tok_data,
        input  tok_last,
        output tok_ready
    );
endinterface

// File: rtl/postfix_evaluator.sv
// Stack-based postfix evaluator: pushes operands, applies + - * to the top two entries,
// and reports the final value or the first error with a one-cycle done pulse.
module postfix_evaluator #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 11,
    localparam int SPW  = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    postfix_evaluator_if.slave  tok,
    output logic                done,
    output logic [WIDTH-1:0]    result,
    output logic [2:0]          err_code,
    output logic [1:0]          dbg_state,
    output logic [SPW-1:0]      dbg_sp
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;

    localparam logic [2:0] E_NONE  = 3'd0;
    localparam logic [2:0] E_OVF   = 3'd1;
    localparam logic [2:0] E_UNF   = 3'd2;
    localparam logic [2:0] E_BAD   = 3'd3;
    localparam logic [2:0] E_DEPTH = 3'd4;

    logic [1:0]       state, state_n;
    logic [SPW-1:0]   sp, sp_n;
    logic [2:0]       err, err_n;
    logic [1:0]       op_code;
    logic             op_last;
    logic [WIDTH-1:0] stack [DEPTH];

    logic             xfer;
    logic             is_add, is_sub, is_mul, op_ok;
    logic             push_en, exec_en, latch_en;
    logic [SPW-1:0]   top_idx, nxt_idx;
    logic [WIDTH-1:0] opa, opb, alu_res, stack0_n;
    logic             fin;
    logic [2:0]       fin_err;

    assign tok.tok_ready = !rst && (state == S_RUN || state == S_DRAIN);
    assign xfer          = tok.tok_valid && tok.tok_ready;

    assign is_add = tok.tok_data == WIDTH'(43);
    assign is_sub = tok.tok_data == WIDTH'(45);
    assign is_mul = tok.tok_data == WIDTH'(42);
    assign op_ok  = is_add || is_sub || is_mul;

    assign top_idx = sp - SPW'(1);
    assign nxt_idx = sp - SPW'(2);
    assign opa     = stack[nxt_idx];
    assign opb     = stack[top_idx];

    always_comb begin
        alu_res = '0;
        case (op_code)
            OP_ADD:  alu_res = opa + opb;
            OP_SUB:  alu_res = opa - opb;
            default: alu_res = opa * opb;
        endcase
    end

    // Next-state logic; an already-pending error is never overwritten.
    always_comb begin
        state_n  = state;
        sp_n     = sp;
        err_n    = err;
        push_en  = 1'b0;
        exec_en  = 1'b0;
        latch_en = 1'b0;
        case (state)
            S_RUN: begin
                if (xfer) begin
                    if (!tok.tok_is_op) begin
                        if (sp == SPW'(DEPTH)) begin
                            err_n   = (err != E_NONE) ? err : E_OVF;
                            state_n = tok.tok_last ? S_DONE : S_DRAIN;
                        end else begin
                            push_en = 1'b1;
                            sp_n    = sp + SPW'(1);
                            state_n = tok.tok_last ? S_DONE : S_RUN;
                        end
                    end else if (!op_ok) begin
                        err_n   = (err != E_NONE) ? err : E_BAD;
                        state_n = tok.tok_last ? S_DONE : S_DRAIN;
                    end else if (sp < SPW'(2)) begin
                        err_n   = (err != E_NONE) ? err : E_UNF;
                        state_n = tok.tok_last ? S_DONE : S_DRAIN;
                    end else begin
                        latch_en = 1'b1;
                        state_n  = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                exec_en = 1'b1;
                sp_n    = sp - SPW'(1);
                state_n = op_last ? S_DONE : S_RUN;
            end
            S_DRAIN: begin
                if (xfer && tok.tok_last) begin
                    state_n = S_DONE;
                end
            end
            default: begin
                sp_n    = '0;
                err_n   = E_NONE;
                state_n = S_RUN;
            end
        endcase
    end

    // Result is registered on the edge entering DONE, so it uses next-cycle stack/sp values.
    always_comb begin
        stack0_n = stack[0];
        if (push_en && sp == '0) begin
            stack0_n = tok.tok_data;
        end else if (exec_en && sp == SPW'(2)) begin
            stack0_n = alu_res;
        end
    end

    assign fin     = (state_n == S_DONE) && (state != S_DONE);
    assign fin_err = (err_n != E_NONE) ? err_n :
                     (sp_n != SPW'(1)) ? E_DEPTH : E_NONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_RUN;
            sp       <= '0;
            err      <= E_NONE;
            op_code  <= OP_ADD;
            op_last  <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            err_code <= E_NONE;
        end else begin
            state <= state_n;
            sp    <= sp_n;
            err   <= err_n;
            done  <= fin;
            if (latch_en) begin
                op_code <= is_add ? OP_ADD : (is_sub ? OP_SUB : OP_MUL);
                op_last <= tok.tok_last;
            end
            if (fin) begin
                err_code <= fin_err;
                result   <= (fin_err == E_NONE) ? stack0_n : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            stack[sp] <= tok.tok_data;
        end else if (exec_en) begin
            stack[nxt_idx] <= alu_res;
        end
    end

    assign dbg_state = state;
    assign dbg_sp    = sp;

endmodule
